wb_arbiter: RTL and testbench

Writeback arbiter that owns the single write port of the 8×16 register file. Merges single-cycle ALU results with variable-latency load results, buffering loads in a small FIFO. Drives the register-file write port from registered outputs, so each accepted result produces exactly one write. Sits between the execute/memory stages and `register_file`.

---
 rtl/wb_arbiter_if.sv | 49 ++++
 rtl/wb_arbiter.sv | 156 +++++++++++++++
 tb/tb_wb_arbiter.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter_if.sv
// ---------------------------------------------------------------------------
// wb_arbiter_if
// Bundles the execute/memory-side handshakes and the register-file write port
// of the writeback arbiter.
//   master : upstream side (drives ALU/load results and flush, observes status)
//   slave  : arbiter side
// Signals:
//   alu_valid/alu_dest/alu_data  ALU result, no backpressure except alu_stall
//   alu_stall                    upstream must hold off alu_valid while high
//   ld_valid/ld_ready/ld_dest/ld_data  load result handshake
//   flush                        discard queued and incoming loads
//   rf_write_*                   registered write port to register_file
//   lq_count                     queued load entries
//   proto_err                    sticky: alu_valid seen while alu_stall high
// ---------------------------------------------------------------------------
interface wb_arbiter_if #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter int LQ_DEPTH = 4
);
  localparam int CNT_W = $clog2(LQ_DEPTH) + 1;

  logic              alu_valid;
  logic [ADDR_W-1:0] alu_dest;
  logic [DATA_W-1:0] alu_data;
  logic              alu_stall;
  logic              ld_valid;
  logic              ld_ready;
  logic [ADDR_W-1:0] ld_dest;
  logic [DATA_W-1:0] ld_data;
  logic              flush;
  logic              rf_write_enable;
  logic [ADDR_W-1:0] rf_write_destination;
  logic [DATA_W-1:0] rf_write_data;
  logic [CNT_W-1:0]  lq_count;
  logic              proto_err;

  modport master (
    output alu_valid, alu_dest, alu_data, ld_valid, ld_dest, ld_data, flush,
    input  alu_stall, ld_ready, rf_write_enable, rf_write_destination,
           rf_write_data, lq_count, proto_err
  );

  modport slave (
    input  alu_valid, alu_dest, alu_data, ld_valid, ld_dest, ld_data, flush,
    output alu_stall, ld_ready, rf_write_enable, rf_write_destination,
           rf_write_data, lq_count, proto_err
  );
endinterface

// File: rtl/wb_arbiter.sv
// ---------------------------------------------------------------------------
// wb_arbiter
// Owns the single write port of the register file. Single-cycle ALU results
// and variable-latency load results are merged; loads always pass through a
// small circular queue. Every selected result is registered onto rf_write_*,
// so each accepted result produces exactly one write.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous, active-high reset
//   bus  wb_arbiter_if.slave (ALU/load inputs, flush, write port, status)
//
// Arbitration each cycle: queue full -> forced pop (ALU ignored, flagged as
// protocol error if valid); else ALU; else pop if queue not empty.
//
// Optional feature macro: WB_R0_ZERO_EN
//   defined   : a selected write to register 0 is suppressed (enable low) but
//               still consumes its ALU cycle or queue slot.
//   undefined : register 0 is written like any other.
// ---------------------------------------------------------------------------
module wb_arbiter #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter int LQ_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  wb_arbiter_if.slave   bus
);
  localparam int PTR_W = $clog2(LQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = ADDR_W + DATA_W;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(LQ_DEPTH);

  // Queue storage: {dest, data}; no reset needed, validity comes from count.
  logic [ENT_W-1:0] lq_mem [LQ_DEPTH];

  logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0]  count_reg,  count_next;
  logic              proto_err_reg, proto_err_next;
  logic              we_reg,   we_next;
  logic [ADDR_W-1:0] dest_reg, dest_next;
  logic [DATA_W-1:0] data_reg, data_next;

  logic              full, empty, push, pop;
  logic              sel_alu, sel_pop;
  logic [ENT_W-1:0]  head;

  assign full  = (count_reg == DEPTH_CNT);
  assign empty = (count_reg == '0);
  assign head  = lq_mem[rd_ptr_reg];

  // ld_ready is forced low during reset so nothing is accepted while the
  // queue state is being cleared.
  assign bus.ld_ready  = !full && !rst;
  assign bus.alu_stall = full;
  assign bus.lq_count  = count_reg;
  assign bus.proto_err = proto_err_reg;
  assign bus.rf_write_enable      = we_reg;
  assign bus.rf_write_destination = dest_reg;
  assign bus.rf_write_data        = data_reg;

  assign push = bus.ld_valid && !full && !flush_in();

  function automatic logic flush_in();
    return bus.flush;
  endfunction

  // A pop chosen in a flush cycle is cancelled: the queue is being discarded.
  assign pop = sel_pop && !bus.flush;

  always_comb begin
    sel_alu        = 1'b0;
    sel_pop        = 1'b0;
    proto_err_next = proto_err_reg;
    if (full) begin
      // Forced pop guarantees progress for loads starved by ALU traffic.
      sel_pop = 1'b1;
      if (bus.alu_valid) begin
        proto_err_next = 1'b1;
      end
    end else if (bus.alu_valid) begin
      sel_alu = 1'b1;
    end else if (!empty) begin
      sel_pop = 1'b1;
    end
  end

  always_comb begin
    dest_next = dest_reg;
    data_next = data_reg;
    if (sel_alu) begin
      dest_next = bus.alu_dest;
      data_next = bus.alu_data;
    end else if (pop) begin
      dest_next = head[ENT_W-1:DATA_W];
      data_next = head[DATA_W-1:0];
    end
`ifdef WB_R0_ZERO_EN
    we_next = (sel_alu || pop) && (dest_next != '0);
`else
    we_next = sel_alu || pop;
`endif
  end

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (bus.flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push) begin
        wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      end
      // Simultaneous push and pop leave the count unchanged.
      if (push && !pop) begin
        count_next = count_reg + CNT_W'(1);
      end else if (pop && !push) begin
        count_next = count_reg - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      lq_mem[wr_ptr_reg] <= {bus.ld_dest, bus.ld_data};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      proto_err_reg <= 1'b0;
      we_reg        <= 1'b0;
      dest_reg      <= '0;
      data_reg      <= '0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= count_next;
      proto_err_reg <= proto_err_next;
      we_reg        <= we_next;
      dest_reg      <= dest_next;
      data_reg      <= data_next;
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_arbiter
// Directed test of wb_arbiter: ALU write latency, load ordering, queue-full
// forced pop, protocol error, flush, asynchronous reset and the optional
// register-0 suppression (WB_R0_ZERO_EN).
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
// ---------------------------------------------------------------------------
module tb_wb_arbiter;
  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  wb_arbiter_if #(.DATA_W(16), .ADDR_W(3), .LQ_DEPTH(4)) bus ();

  wb_arbiter #(.DATA_W(16), .ADDR_W(3), .LQ_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.alu_valid = 1'b0;
    bus.alu_dest  = '0;
    bus.alu_data  = '0;
    bus.ld_valid  = 1'b0;
    bus.ld_dest   = '0;
    bus.ld_data   = '0;
    bus.flush     = 1'b0;
  endtask

  task automatic check_write(input string tag, input logic [2:0] dest, input logic [15:0] data);
    check({tag, ".we"},   32'(bus.rf_write_enable), 32'd1);
    check({tag, ".dest"}, 32'(bus.rf_write_destination), 32'(dest));
    check({tag, ".data"}, 32'(bus.rf_write_data), 32'(data));
  endtask

  // Pushes n loads (dest i+1, data base+i) while the ALU (dest 6) occupies
  // the write port every cycle, so the loads accumulate in the queue.
  task automatic fill(input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) begin
      bus.alu_valid = 1'b1;
      bus.alu_dest  = 3'd6;
      bus.alu_data  = 16'h0100 + 16'(i);
      bus.ld_valid  = 1'b1;
      bus.ld_dest   = 3'(i + 1);
      bus.ld_data   = base + 16'(i);
      tick();
      check_write("fill_alu", 3'd6, 16'h0100 + 16'(i));
      check("fill_count", 32'(bus.lq_count), 32'(i + 1));
    end
    idle_inputs();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_async_we",    32'(bus.rf_write_enable), 32'd0);
    check("rst_async_ready", 32'(bus.ld_ready), 32'd0);
    check("rst_async_perr",  32'(bus.proto_err), 32'd0);
    check("rst_async_count", 32'(bus.lq_count), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_ready", 32'(bus.ld_ready), 32'd1);
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    check("reset_we",    32'(bus.rf_write_enable), 32'd0);
    check("reset_dest",  32'(bus.rf_write_destination), 32'd0);
    check("reset_data",  32'(bus.rf_write_data), 32'd0);
    check("reset_count", 32'(bus.lq_count), 32'd0);
    check("reset_stall", 32'(bus.alu_stall), 32'd0);
    check("reset_ready", 32'(bus.ld_ready), 32'd0);
    check("reset_perr",  32'(bus.proto_err), 32'd0);
    rst = 1'b0;
    #1;
    check("post_reset_ready", 32'(bus.ld_ready), 32'd1);

    // ALU result appears on the write port right after the capturing edge.
    bus.alu_valid = 1'b1;
    bus.alu_dest  = 3'd3;
    bus.alu_data  = 16'h1234;
    tick();
    check_write("alu1", 3'd3, 16'h1234);
    idle_inputs();
    tick();
    check("alu1_done_we", 32'(bus.rf_write_enable), 32'd0);

    // Two loads on consecutive cycles are written back-to-back in order.
    bus.ld_valid = 1'b1;
    bus.ld_dest  = 3'd1;
    bus.ld_data  = 16'hAAAA;
    tick();
    check("ld_push_count", 32'(bus.lq_count), 32'd1);
    check("ld_push_we",    32'(bus.rf_write_enable), 32'd0);
    bus.ld_dest = 3'd2;
    bus.ld_data = 16'hBBBB;
    tick();
    check_write("ld1", 3'd1, 16'hAAAA);
    check("ld_pushpop_count", 32'(bus.lq_count), 32'd1);
    idle_inputs();
    tick();
    check_write("ld2", 3'd2, 16'hBBBB);
    check("ld_drain_count", 32'(bus.lq_count), 32'd0);
    tick();
    check("ld_idle_we", 32'(bus.rf_write_enable), 32'd0);

    // Queue fills under continuous ALU traffic; forced pop then drains it.
    fill(4, 16'hC001);
    check("full_stall", 32'(bus.alu_stall), 32'd1);
    check("full_ready", 32'(bus.ld_ready), 32'd0);
    tick();
    check_write("forced_pop", 3'd1, 16'hC001);
    check("forced_stall", 32'(bus.alu_stall), 32'd0);
    check("forced_count", 32'(bus.lq_count), 32'd3);
    check("forced_perr",  32'(bus.proto_err), 32'd0);
    for (int i = 1; i < 4; i++) begin
      tick();
      check_write("drain", 3'(i + 1), 16'hC001 + 16'(i));
    end
    check("drain_count", 32'(bus.lq_count), 32'd0);
    tick();
    check("drain_idle_we", 32'(bus.rf_write_enable), 32'd0);

    // Register 0 handling depends on the optional feature.
    bus.alu_valid = 1'b1;
    bus.alu_dest  = 3'd0;
    bus.alu_data  = 16'h7777;
    tick();
`ifdef WB_R0_ZERO_EN
    check("r0_we", 32'(bus.rf_write_enable), 32'd0);
`else
    check_write("r0", 3'd0, 16'h7777);
`endif
    idle_inputs();
    tick();

    // ALU offered while stalled: ignored, sticky protocol error.
    fill(4, 16'hE000);
    bus.alu_valid = 1'b1;
    bus.alu_dest  = 3'd7;
    bus.alu_data  = 16'hDEAD;
    tick();
    check_write("perr_pop", 3'd1, 16'hE000);
    check("perr_set",   32'(bus.proto_err), 32'd1);
    check("perr_count", 32'(bus.lq_count), 32'd3);
    idle_inputs();
    for (int i = 1; i < 4; i++) begin
      tick();
      check_write("perr_drain", 3'(i + 1), 16'hE000 + 16'(i));
    end
    tick();
    check("perr_sticky", 32'(bus.proto_err), 32'd1);
    check("perr_idle_we", 32'(bus.rf_write_enable), 32'd0);
    do_reset();

    // Flush with 3 queued loads, a new load and an ALU result.
    fill(3, 16'h5000);
    bus.flush     = 1'b1;
    bus.ld_valid  = 1'b1;
    bus.ld_dest   = 3'd4;
    bus.ld_data   = 16'h9999;
    bus.alu_valid = 1'b1;
    bus.alu_dest  = 3'd5;
    bus.alu_data  = 16'h0F0F;
    tick();
    check_write("flush_alu", 3'd5, 16'h0F0F);
    check("flush_count", 32'(bus.lq_count), 32'd0);
    idle_inputs();
    tick();
    check("flush_after_we",    32'(bus.rf_write_enable), 32'd0);
    check("flush_after_count", 32'(bus.lq_count), 32'd0);

    // Flush alone cancels the pop selected in that cycle.
    fill(2, 16'h6000);
    bus.flush = 1'b1;
    tick();
    check("flush_pop_we",    32'(bus.rf_write_enable), 32'd0);
    check("flush_pop_count", 32'(bus.lq_count), 32'd0);
    idle_inputs();
    tick();
    check("flush_pop_idle_we", 32'(bus.rf_write_enable), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
